// File: rtl/img_vline_fetch_ctrl_pkg.sv
// Shared types and constants for the vertical line fetch controller.
// Holds the FSM encoding, the frame/source geometry and the Q10.5 table-entry layout.
package img_vline_fetch_ctrl_pkg;

   localparam int unsigned V_ACTIVE   = 1080;
   localparam int unsigned SRC_H      = 480;
   localparam int unsigned TAB_AW     = 11;
   localparam int unsigned TAB_DW     = 16;
   localparam int unsigned LINE_BYTES = 1280;
   localparam int unsigned BASE_ADDR  = 0;
   localparam int unsigned MEM_AW     = 24;
   localparam int unsigned INT_W      = 10;
   localparam int unsigned FRAC_W     = 5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TAB  = 3'd1,
      ST_DEC  = 3'd2,
      ST_REQ  = 3'd3,
      ST_BUSY = 3'd4,
      ST_RDY  = 3'd5
   } state_t;

   typedef struct packed {
      logic              vld;
      logic [INT_W-1:0]  int_part;
      logic [FRAC_W-1:0] frac;
   } tab_entry_t;

   // Nearest-neighbour source line, limited to the last line of the source image.
   function automatic logic [INT_W-1:0] clamp_src(input logic [INT_W-1:0] int_part);
      return (int_part > INT_W'(SRC_H - 1)) ? INT_W'(SRC_H - 1) : int_part;
   endfunction

endpackage

// File: rtl/img_vline_fetch_ctrl_addr_calc.sv
// Source-line clamp and frame-buffer address computation, one register stage.
// src_c is available combinationally for the reuse compare; src/addr register on ld.
module img_vline_fetch_ctrl_addr_calc
   import img_vline_fetch_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic [INT_W-1:0]  int_part,
   output logic [INT_W-1:0]  src_c,
   output logic [INT_W-1:0]  src,
   output logic [MEM_AW-1:0] addr
);

   assign src_c = clamp_src(int_part);

   always_ff @(posedge clk) begin
      if (rst) begin
         src  <= '0;
         addr <= '0;
      end else if (ld) begin
         src  <= src_c;
         addr <= MEM_AW'(BASE_ADDR) + MEM_AW'(src_c) * MEM_AW'(LINE_BYTES);
      end
   end

endmodule

// File: rtl/img_vline_fetch_ctrl.sv
// Per-output-line fetch controller: reads the vertical line table, picks the source line
// and fetches it into a ping-pong buffer unless that line is already buffered.
module img_vline_fetch_ctrl
   import img_vline_fetch_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_frame_start,
   input  logic              i_line_req,
   output logic [TAB_AW-1:0] o_tab_raddr,
   output logic              o_tab_re,
   input  logic [TAB_DW-1:0] i_tab_rdata,
   input  logic              i_tab_rvld,
   output logic              o_rd_req,
   output logic [MEM_AW-1:0] o_rd_addr,
   output logic              o_rd_buf,
   input  logic              i_rd_ack,
   input  logic              i_rd_done,
   output logic              o_line_ready,
   output logic              o_line_blank,
   output logic              o_line_buf,
   output logic [INT_W-1:0]  o_line_idx,
   output logic              o_overrun
);

   state_t            state;
   state_t            state_nxt;
   tab_entry_t        tab_in;
   logic              frac_unused;
   logic              tab_vld;
   logic [INT_W-1:0]  tab_int;
   logic [INT_W-1:0]  src_c;
   logic [INT_W-1:0]  src;
   logic [INT_W-1:0]  last_src;
   logic              last_vld;
   logic              buf_sel;
   logic              done_seen;
   logic              drop;
   logic [TAB_AW-1:0] line_cnt;
   logic              fetch_c;
   logic              done_c;
   logic              tab_re_c;
   logic              rd_req_c;
   logic              ready_c;
   logic              overrun_c;

   assign tab_in      = i_tab_rdata;
   assign frac_unused = ^tab_in.frac;

   img_vline_fetch_ctrl_addr_calc u_addr_calc (
      .clk      (clk),
      .rst      (rst),
      .ld       (state == ST_DEC),
      .int_part (tab_int),
      .src_c    (src_c),
      .src      (src),
      .addr     (o_rd_addr)
   );

   // A valid entry needs a fetch unless its source line is the one already buffered.
   assign fetch_c = tab_vld && !(last_vld && (src_c == last_src));
   // Done arriving together with ack is remembered so BUSY leaves on its first cycle.
   assign done_c  = i_rd_done || done_seen;
   assign o_rd_buf = buf_sel;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (i_line_req && !i_frame_start) state_nxt = ST_TAB;
         ST_TAB: begin
            if (i_frame_start)   state_nxt = ST_IDLE;
            else if (i_tab_rvld) state_nxt = ST_DEC;
         end
         ST_DEC: begin
            if (i_frame_start) state_nxt = ST_IDLE;
            else if (fetch_c)  state_nxt = ST_REQ;
            else               state_nxt = ST_RDY;
         end
         ST_REQ:  if (i_rd_ack) state_nxt = ST_BUSY;
         // A request is never aborted; a frame start only suppresses the ready pulse.
         ST_BUSY: if (done_c) state_nxt = (drop || i_frame_start) ? ST_IDLE : ST_RDY;
         ST_RDY:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tab_re_c  = 1'b0;
      rd_req_c  = 1'b0;
      ready_c   = 1'b0;
      overrun_c = 1'b0;
      tab_re_c  = (state == ST_IDLE) && i_line_req && !i_frame_start;
      rd_req_c  = (state_nxt == ST_REQ);
      ready_c   = (state == ST_RDY) && !i_frame_start;
      overrun_c = (state != ST_IDLE) && i_line_req && !i_frame_start;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_tab_re     <= 1'b0;
         o_tab_raddr  <= '0;
         o_rd_req     <= 1'b0;
         o_line_ready <= 1'b0;
         o_line_blank <= 1'b0;
         o_line_buf   <= 1'b0;
         o_line_idx   <= '0;
         o_overrun    <= 1'b0;
      end else begin
         o_tab_re     <= tab_re_c;
         o_rd_req     <= rd_req_c;
         o_line_ready <= ready_c;
         o_line_blank <= ready_c && !tab_vld;
         o_line_buf   <= ready_c && buf_sel;
         o_line_idx   <= ready_c ? src : '0;
         o_overrun    <= overrun_c;
         if (tab_re_c) o_tab_raddr <= line_cnt;
      end
   end

   // Line bookkeeping: table capture, buffer toggle, handshake flags and line counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         tab_vld   <= 1'b0;
         tab_int   <= '0;
         buf_sel   <= 1'b0;
         done_seen <= 1'b0;
         drop      <= 1'b0;
         last_src  <= '0;
         last_vld  <= 1'b0;
         line_cnt  <= '0;
      end else begin
         if ((state == ST_TAB) && i_tab_rvld) begin
            tab_vld <= tab_in.vld;
            tab_int <= tab_in.int_part;
         end
         if ((state == ST_DEC) && !i_frame_start && fetch_c) buf_sel <= ~buf_sel;
         if (state == ST_REQ) done_seen <= i_rd_ack && i_rd_done;
         if (i_frame_start && ((state == ST_REQ) || (state == ST_BUSY))) drop <= 1'b1;
         else if (state == ST_IDLE)                                       drop <= 1'b0;
         if (i_frame_start) begin
            last_vld <= 1'b0;
         end else if ((state == ST_BUSY) && done_c && !drop) begin
            last_src <= src;
            last_vld <= 1'b1;
         end
         if (i_frame_start) begin
            line_cnt <= '0;
         end else if (state == ST_RDY) begin
            line_cnt <= (line_cnt == TAB_AW'(V_ACTIVE - 1)) ? '0 : line_cnt + TAB_AW'(1);
         end
      end
   end

endmodule
